iter_divider: RTL and testbench

- Multi-cycle restoring integer divider in the ALU.
- Each iteration feeds the partial remainder and divisor through one subtractor instance. The subtractor's borrow_out decides the quotient bit and whether the remainder restores.
- Produces one quotient bit per clock. Serves DIV/DIVU/REM/REMU through a start/busy/done handshake with the execute stage.

---
 rtl/iter_divider.sv | 169 ++++++++++++++++
 tb/tb_iter_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock through a
// single subtractor, with signed fix-up and divide-by-zero handling at the end.

module iter_divider_sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};
endmodule

module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] orig_dvd_q, orig_dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dvz_q, dvz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign accept    = start && (state_q != RUN);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign rem_sh    = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  iter_divider_sub #(.W(WIDTH)) u_sub (
    .a          (rem_sh),
    .b          (dsr_q),
    .diff       (sub_diff),
    .borrow_out (sub_borrow)
  );

  // The bit shifted out of rem_q is an implicit guard: when set, the shifted
  // remainder exceeds any WIDTH-bit divisor, so the subtraction always succeeds.
  assign q_bit   = rem_q[WIDTH-1] | ~sub_borrow;
  assign rem_nxt = q_bit ? sub_diff : rem_sh;
  assign dvd_nxt = {dvd_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      orig_dvd_q  <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      orig_dvd_q  <= orig_dvd_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dvz_q       <= dvz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    orig_dvd_d  = orig_dvd_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dvz_d       = dvz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (accept) begin
      rem_d       = '0;
      dvd_d       = mag(dividend, is_signed);
      dsr_d       = mag(divisor, is_signed);
      orig_dvd_d  = dividend;
      cnt_d       = '0;
      neg_quo_d   = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_d   = is_signed && dividend[WIDTH-1];
      dvz_d       = (divisor == '0);
      quotient_d  = '0;
      remainder_d = '0;
      dbz_d       = 1'b0;
    end else if (state_q == RUN) begin
      rem_d = rem_nxt;
      dvd_d = dvd_nxt;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        if (dvz_q) begin
          quotient_d  = '1;
          remainder_d = orig_dvd_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = neg_quo_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
          remainder_d = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
          dbz_d       = 1'b0;
        end
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Randomised self-checking bench for iter_divider against an arithmetic
// reference model, plus directed handshake and reset scenarios.

module tb_iter_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {div_by_zero, quotient, remainder} from plain integer arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0]        ones;
    logic [W-1:0]        minv;
    logic signed [W-1:0] sa, sb, sq, sr;
    ones = '1;
    minv = {1'b1, {(W-1){1'b0}}};
    if (b == '0) return {1'b1, ones, a};
    if (s) begin
      if (a == minv && b == ones) return {1'b0, a, {W{1'b0}}};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sq, sr};
    end
    return {1'b0, a / b, a % b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s);
    logic [2*W:0] e;
    e = model(a, b, s);
    check_eq({tag, ".quo"}, quotient, e[2*W-1:W]);
    check_eq({tag, ".rem"}, remainder, e[W-1:0]);
    check_eq({tag, ".dbz"}, div_by_zero, e[2*W]);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
    int cyc;
    start_op(a, b, s);
    check_eq({tag, ".busy_on"}, busy, 1);
    check_eq({tag, ".cleared"}, {done, quotient, remainder, div_by_zero}, 0);
    wait_done(cyc);
    check_eq({tag, ".latency"}, cyc, W);
    check_result(tag, a, b, s);
    check_eq({tag, ".busy_off"}, busy, 0);
    tick();
    check_eq({tag, ".done_pulse"}, done, 0);
    check_result({tag, ".hold"}, a, b, s);
  endtask

  initial begin
    int           cyc;
    logic [W-1:0] a, b;
    logic         s;
    bit           saw_done;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    tick();
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    check_eq("reset.outs", {busy, done, quotient, remainder, div_by_zero}, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    check_eq("reset.idle", {busy, done}, 0);

    full_op("u100_7", 32'd100, 32'd7, 1'b0);
    check_eq("u100_7.const", {quotient, remainder}, {32'd14, 32'd2});
    full_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_eq("s-7_2.const", {quotient, remainder}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    full_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    check_eq("s7_-2.const", {quotient, remainder}, {32'hFFFF_FFFD, 32'd1});
    full_op("s5_0", 32'd5, 32'd0, 1'b1);
    full_op("u5_0", 32'd5, 32'd0, 1'b0);
    full_op("s-5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
    full_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_eq("s_ovf.const", {quotient, remainder}, {32'h8000_0000, 32'd0});
    full_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    full_op("u_max_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    full_op("u_big_big", 32'h8000_0001, 32'h8000_0000, 1'b0);
    full_op("s_min_1", 32'h8000_0000, 32'd1, 1'b1);

    // start while busy is ignored
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    check_eq("busy_ign.latency", cyc, W - 10);
    check_eq("busy_ign.result", {quotient, remainder}, {32'd14, 32'd2});

    // start during the DONE cycle is accepted back-to-back
    start_op(32'd9, 32'd3, 1'b0);
    check_eq("b2b.busy", busy, 1);
    check_eq("b2b.cleared", {done, quotient, remainder}, 0);
    wait_done(cyc);
    check_eq("b2b.latency", cyc, W);
    check_eq("b2b.result", {quotient, remainder, div_by_zero}, {32'd3, 32'd0, 1'b0});
    tick();

    // reset mid-operation aborts with no done
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort.outs", {busy, done, quotient, remainder, div_by_zero}, 0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check_eq("abort.no_done", saw_done, 0);
    full_op("post_rst", 32'd1000, 32'd3, 1'b0);

    // randomised operations, biased toward interesting divisors
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = b >> $urandom_range(0, 31);
        2: a = a >> $urandom_range(0, 31);
        3: b = {W{1'b1}} - 32'($urandom_range(0, 3));
        default: ;
      endcase
      start_op(a, b, s);
      wait_done(cyc);
      check_eq("rand.latency", cyc, W);
      check_result("rand", a, b, s);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
